// File: rtl/regwrite_arbiter_if.sv
// Register-file write arbiter bus: two requester write channels plus the
// registered write port and stall counter.
interface regwrite_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  // Handshake: a write transfers on a posedge where reqN_valid && reqN_ready;
  // valid may not depend on ready, and reg/data are ignored when no transfer occurs.
  logic          req0_valid;
  logic          req0_ready;
  logic [AW-1:0] req0_reg;
  logic [DW-1:0] req0_data;
  logic          req1_valid;
  logic          req1_ready;
  logic [AW-1:0] req1_reg;
  logic [DW-1:0] req1_data;
  logic [AW-1:0] Writereg;
  logic [DW-1:0] Writedata;
  logic          RegWrite;
  logic          grant_id;
  logic [7:0]    stall_cnt;

  modport master (
    output req0_valid, req0_reg, req0_data,
    output req1_valid, req1_reg, req1_data,
    input  req0_ready, req1_ready,
    input  Writereg, Writedata, RegWrite, grant_id, stall_cnt
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data,
    input  req1_valid, req1_reg, req1_data,
    output req0_ready, req1_ready,
    output Writereg, Writedata, RegWrite, grant_id, stall_cnt
  );
endinterface

// File: rtl/regwrite_arbiter.sv
// Two-requester register-file write arbiter with one holding slot per requester.
// Define REGARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority (req0 wins).
module regwrite_arbiter #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic               clock,
  input  logic               reset_n,
  regwrite_arbiter_if.slave  bus
);

  logic          full0_q, full0_d;
  logic [AW-1:0] reg0_q, reg0_d;
  logic [DW-1:0] data0_q, data0_d;
  logic          full1_q, full1_d;
  logic [AW-1:0] reg1_q, reg1_d;
  logic [DW-1:0] data1_q, data1_d;

  logic [AW-1:0] wreg_q, wreg_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          regwrite_q, regwrite_d;
  logic          gid_q, gid_d;
  logic [7:0]    stall_q, stall_d;

`ifdef REGARB_ROUND_ROBIN_EN
  logic          last_grant_q, last_grant_d;
`endif

  logic contend0, contend1;
  logic grant0, grant1;
  logic ready0, ready1;
  logic hs0, hs1;

  // Writes to register 0 are meaningless; such slots never contend and just drain.
  assign contend0 = full0_q && (reg0_q != '0);
  assign contend1 = full1_q && (reg1_q != '0);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef REGARB_ROUND_ROBIN_EN
    if (contend0 && contend1) begin
      grant0 = last_grant_q;
      grant1 = !last_grant_q;
    end else begin
      grant0 = contend0;
      grant1 = contend1;
    end
`else
    grant0 = contend0;
    grant1 = contend1 && !contend0;
`endif
  end

  assign ready0 = !full0_q || grant0;
  assign ready1 = !full1_q || grant1;
  assign hs0    = bus.req0_valid && ready0;
  assign hs1    = bus.req1_valid && ready1;

  always_comb begin
    full0_d = full0_q;
    reg0_d  = reg0_q;
    data0_d = data0_q;
    full1_d = full1_q;
    reg1_d  = reg1_q;
    data1_d = data1_q;

    // A new entry overwrites a slot being granted this cycle, giving 1/cycle throughput.
    if (hs0) begin
      full0_d = 1'b1;
      reg0_d  = bus.req0_reg;
      data0_d = bus.req0_data;
    end else if (grant0 || (full0_q && !contend0)) begin
      full0_d = 1'b0;
    end

    if (hs1) begin
      full1_d = 1'b1;
      reg1_d  = bus.req1_reg;
      data1_d = bus.req1_data;
    end else if (grant1 || (full1_q && !contend1)) begin
      full1_d = 1'b0;
    end
  end

  always_comb begin
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    gid_d      = gid_q;
    regwrite_d = 1'b0;
    stall_d    = stall_q;
`ifdef REGARB_ROUND_ROBIN_EN
    last_grant_d = last_grant_q;
`endif

    if (grant0) begin
      regwrite_d = 1'b1;
      wreg_d     = reg0_q;
      wdata_d    = data0_q;
      gid_d      = 1'b0;
    end else if (grant1) begin
      regwrite_d = 1'b1;
      wreg_d     = reg1_q;
      wdata_d    = data1_q;
      gid_d      = 1'b1;
    end

`ifdef REGARB_ROUND_ROBIN_EN
    if (grant0 || grant1) begin
      last_grant_d = grant1;
    end
`endif

    if (((contend0 && !grant0) || (contend1 && !grant1)) && (stall_q != 8'hFF)) begin
      stall_d = stall_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full0_q    <= 1'b0;
      reg0_q     <= '0;
      data0_q    <= '0;
      full1_q    <= 1'b0;
      reg1_q     <= '0;
      data1_q    <= '0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      regwrite_q <= 1'b0;
      gid_q      <= 1'b0;
      stall_q    <= 8'd0;
    end else begin
      full0_q    <= full0_d;
      reg0_q     <= reg0_d;
      data0_q    <= data0_d;
      full1_q    <= full1_d;
      reg1_q     <= reg1_d;
      data1_q    <= data1_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      regwrite_q <= regwrite_d;
      gid_q      <= gid_d;
      stall_q    <= stall_d;
    end
  end

`ifdef REGARB_ROUND_ROBIN_EN
  // Starts at 1 so requester 0 wins the first contention after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`endif

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;
  assign bus.Writereg   = wreg_q;
  assign bus.Writedata  = wdata_q;
  assign bus.RegWrite   = regwrite_q;
  assign bus.grant_id   = gid_q;
  assign bus.stall_cnt  = stall_q;

endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 SHALL provide parameter DW, default 32, meaning the write-data width.
REQ-002 SHALL provide parameter AW, default 5, meaning the register-address width (32 registers).
REQ-003 SHALL provide port clock, input, 1, the single clock; all state updates on posedge.
REQ-004 SHALL provide port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL provide ports req0_valid input 1 and req1_valid input 1, meaning a requester offers a write.
REQ-006 SHALL provide ports req0_ready output 1 and req1_ready output 1, meaning the holding slot can accept the write.
REQ-007 SHALL provide ports req0_reg input AW and req1_reg input AW, giving the target register.
REQ-008 SHALL provide ports req0_data input DW and req1_data input DW, giving the write data.
REQ-009 SHALL provide port Writereg, output, AW, the register-file write address (registered).
REQ-010 SHALL provide port Writedata, output, DW, the register-file write data (registered).
REQ-011 SHALL provide port RegWrite, output, 1, the register-file write enable (registered; the register file samples it on negedge of the same cycle).
REQ-012 SHALL provide port grant_id, output, 1, the requester whose write is on Writereg/Writedata this cycle.
REQ-013 SHALL provide port stall_cnt, output, 8, a saturating count of lost-arbitration cycles.

Function
REQ-014 SHALL keep one holding slot per requester (full flag, reg, data).
REQ-015 SHALL drive reqN_ready = !fullN | grantN, combinationally; a handshake occurs when reqN_valid & reqN_ready at posedge.
REQ-016 SHALL load slot N on handshake; if slot N was granted in the same cycle, the new entry replaces it (back-to-back throughput 1/cycle per requester when uncontested).
REQ-017 SHALL, each cycle, discard a full slot whose reg is 0 at the next posedge without granting it and without asserting RegWrite; that slot does not contend.
REQ-018 SHALL grant at most one full, nonzero-reg slot per cycle; the granted entry loads Writereg/Writedata/grant_id with RegWrite=1 at the next posedge and clears the slot.
REQ-019 SHALL load RegWrite=0 at posedge when nothing is granted; Writereg/Writedata/grant_id hold their previous values.
REQ-020 SHALL give latency of exactly 1 cycle: an entry accepted at edge k and granted in cycle k..k+1 appears on outputs after edge k+1.
REQ-021 SHALL NOT merge or reorder entries targeting the same register; both are written in grant order.
REQ-022 SHALL increment stall_cnt at posedge for each cycle with a full, nonzero-reg slot not granted, saturating at 255.
REQ-023 SHALL ignore reqN_reg/reqN_data when no handshake occurs.

Reset
REQ-024 SHALL, on reset_n low (asynchronous), clear both full flags, RegWrite=0, Writereg=0, Writedata=0, grant_id=0, stall_cnt=0, and set the round-robin pointer last_grant=1.
REQ-025 SHALL discard slot contents on reset mid-operation; no write issues from a pre-reset entry.
REQ-026 SHALL keep req0_ready and req1_ready at 1 while in reset.

Configuration
REQ-027 SHALL, with REGARB_ROUND_ROBIN_EN defined, grant the requester not equal to last_grant when both slots contend, and update last_grant on every grant.
REQ-028 SHALL, without REGARB_ROUND_ROBIN_EN, use fixed priority: req0 always wins contention, and last_grant does not exist.

Verification
REQ-029 SHALL cover: reset release; req0 write reg 5 data 0xDEADBEEF -> next edge RegWrite=1, Writereg=5, Writedata=0xDEADBEEF, grant_id=0.
REQ-030 SHALL cover: both valid same cycle (reg 3/0x11, reg 4/0x22) with round-robin -> req0 first, req1 next cycle, stall_cnt=1, and req1_ready=0 during the stall.
REQ-031 SHALL cover: req1 held valid with reg 7 for 10 cycles while req0 streams, without the macro -> req1 starved, stall_cnt=10; and with the macro -> alternating grants.
REQ-032 SHALL cover: req0 reg 0 data 0xFFFFFFFF with req1 reg 9 -> slot0 dropped, RegWrite only for reg 9, stall_cnt unchanged.
REQ-033 SHALL cover: reset_n asserted mid-cycle with both slots full -> outputs zero immediately, no RegWrite after release.
REQ-034 SHALL cover: 300 contended cycles -> stall_cnt saturates at 255.
